// File: rtl/pll_reset_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : pll_reset_sequencer_if
// Purpose  : PLL control/status bundle between the reset sequencer (master)
//            and the PLL / PLL-clocked consumers (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface pll_reset_sequencer_if;
  logic       pll_lock;
  logic       pll_reset;
  logic       sys_rst;
  logic       ready;
  logic       lock_lost;
  logic [2:0] retry_cnt;
  logic       fault;

  modport master (
    input  pll_lock,
    output pll_reset, sys_rst, ready, lock_lost, retry_cnt, fault
  );

  modport slave (
    output pll_lock,
    input  pll_reset, sys_rst, ready, lock_lost, retry_cnt, fault
  );
endinterface
`default_nettype wire

// File: rtl/pll_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pll_reset_sequencer
// Purpose  : Drives PLL RESET, qualifies LOCK, holds system/SDRAM reset until
//            lock is stable and the SDRAM power-up wait has elapsed. Retries
//            on lock timeout and latches FAULT after MAX_RETRY failures.
// Revision : 1.0 - initial release
// ============================================================================
module pll_reset_sequencer #(
  parameter int unsigned PLL_RST_CYCLES      = 16,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 50000,
  parameter int unsigned INIT_WAIT_CYCLES    = 10000,
  parameter int unsigned MAX_RETRY           = 7
) (
  input  wire logic               clkin,
  input  wire logic               rst,
  pll_reset_sequencer_if.master   bus
);

  localparam int unsigned C_MAX_AB  = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ?
                                      PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
  localparam int unsigned C_MAX_CD  = (LOCK_TIMEOUT_CYCLES > INIT_WAIT_CYCLES) ?
                                      LOCK_TIMEOUT_CYCLES : INIT_WAIT_CYCLES;
  localparam int unsigned C_MAX_ALL = (C_MAX_AB > C_MAX_CD) ? C_MAX_AB : C_MAX_CD;
  localparam int unsigned CW        = $clog2(C_MAX_ALL) + 1;

  localparam logic [CW-1:0] C_RST_LAST  = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] C_STAB_LAST = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] C_TMO_LAST  = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] C_INIT_LAST = CW'(INIT_WAIT_CYCLES - 1);
  localparam logic [2:0]    C_MAX_RETRY = 3'(MAX_RETRY);

  typedef enum logic [2:0] {
    ST_PLLRST   = 3'd0,
    ST_WAITLOCK = 3'd1,
    ST_INITWAIT = 3'd2,
    ST_RUN      = 3'd3,
    ST_FAULT    = 3'd4
  } state_t;

  state_t        r_state;
  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_stab;
  logic [CW-1:0] r_tmo;
  logic [2:0]    r_retry;
  logic          r_lost;

  logic          w_lock_sync;
  logic [2:0]    w_retry_inc;

  assign w_lock_sync = r_sync[1];
  assign w_retry_inc = r_retry + 3'd1;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == {CW{1'b1}}) ? v : v + CW'(1);
  endfunction

  // Two-flop synchroniser for the asynchronous LOCK pin.
  always_ff @(posedge clkin) begin
    if (rst) begin
      r_sync <= 2'b00;
    end else begin
      r_sync <= {r_sync[0], bus.pll_lock};
    end
  end

  // Sequencer: every transition clears all three counters so each state starts counting from zero.
  always_ff @(posedge clkin) begin
    if (rst) begin
      r_state <= ST_PLLRST;
      r_cnt   <= '0;
      r_stab  <= '0;
      r_tmo   <= '0;
      r_retry <= 3'd0;
      r_lost  <= 1'b0;
    end else begin
      r_lost <= 1'b0;
      case (r_state)
        ST_PLLRST: begin
          if (r_cnt == C_RST_LAST) begin
            r_state <= ST_WAITLOCK;
            r_cnt   <= '0;
            r_stab  <= '0;
            r_tmo   <= '0;
          end else begin
            r_cnt <= sat_inc(r_cnt);
          end
        end
        ST_WAITLOCK: begin
          r_tmo  <= sat_inc(r_tmo);
          r_stab <= w_lock_sync ? sat_inc(r_stab) : '0;
          // Stable lock takes priority over a coincident timeout.
          if (w_lock_sync && (r_stab == C_STAB_LAST)) begin
            r_state <= ST_INITWAIT;
            r_cnt   <= '0;
            r_stab  <= '0;
            r_tmo   <= '0;
          end else if (r_tmo == C_TMO_LAST) begin
            r_retry <= w_retry_inc;
            r_state <= (w_retry_inc == C_MAX_RETRY) ? ST_FAULT : ST_PLLRST;
            r_cnt   <= '0;
            r_stab  <= '0;
            r_tmo   <= '0;
          end
        end
        ST_INITWAIT: begin
          if (!w_lock_sync) begin
            r_state <= ST_PLLRST;
            r_lost  <= 1'b1;
            r_cnt   <= '0;
            r_stab  <= '0;
            r_tmo   <= '0;
          end else if (r_cnt == C_INIT_LAST) begin
            r_state <= ST_RUN;
            r_retry <= 3'd0;
            r_cnt   <= '0;
            r_stab  <= '0;
            r_tmo   <= '0;
          end else begin
            r_cnt <= sat_inc(r_cnt);
          end
        end
        ST_RUN: begin
          if (!w_lock_sync) begin
            r_state <= ST_PLLRST;
            r_lost  <= 1'b1;
            r_cnt   <= '0;
            r_stab  <= '0;
            r_tmo   <= '0;
          end
        end
        ST_FAULT: begin
          r_state <= ST_FAULT;
        end
        default: begin
          r_state <= ST_PLLRST;
          r_cnt   <= '0;
          r_stab  <= '0;
          r_tmo   <= '0;
        end
      endcase
    end
  end

  // Moore outputs decoded straight from the state register.
  assign bus.pll_reset = (r_state == ST_PLLRST);
  assign bus.sys_rst   = (r_state != ST_RUN);
  assign bus.ready     = (r_state == ST_RUN);
  assign bus.fault     = (r_state == ST_FAULT);
  assign bus.lock_lost = r_lost;
  assign bus.retry_cnt = r_retry;

endmodule
`default_nettype wire

// File: tb/tb_pll_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pll_reset_sequencer
// Purpose  : Directed scenarios plus random LOCK/reset traffic for
//            pll_reset_sequencer, compared every cycle to a phase/countdown
//            reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pll_reset_sequencer;
  localparam int PLL_RST = 4;
  localparam int STABLE  = 8;
  localparam int TIMEOUT = 20;
  localparam int INIT    = 16;
  localparam int MAXR    = 2;

  logic clkin = 1'b0;
  logic rst   = 1'b1;
  always #10 clkin = ~clkin;

  pll_reset_sequencer_if bus ();

  pll_reset_sequencer #(
    .PLL_RST_CYCLES      (PLL_RST),
    .LOCK_STABLE_CYCLES  (STABLE),
    .LOCK_TIMEOUT_CYCLES (TIMEOUT),
    .INIT_WAIT_CYCLES    (INIT),
    .MAX_RETRY           (MAXR)
  ) dut (
    .clkin (clkin),
    .rst   (rst),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: phase name, cycles left in the phase, lock cycles still needed.
  typedef enum int {M_RESETTING, M_WAITING, M_POWERUP, M_RUNNING, M_DEAD} mphase_t;
  mphase_t m_ph     = M_RESETTING;
  int      m_left   = PLL_RST;
  int      m_need   = STABLE;
  int      m_tleft  = TIMEOUT;
  int      m_retry  = 0;
  bit      m_lost   = 1'b0;
  bit      m_lock_hist[$] = '{1'b0, 1'b0};

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit l);
    bit ls;
    if (r) begin
      m_ph = M_RESETTING; m_left = PLL_RST; m_retry = 0; m_lost = 1'b0;
      m_lock_hist = '{1'b0, 1'b0};
      return;
    end
    ls = m_lock_hist[0];      // what LOCK looked like two cycles ago
    m_lost = 1'b0;
    if (m_ph == M_RESETTING) begin
      m_left--;
      if (m_left == 0) begin m_ph = M_WAITING; m_need = STABLE; m_tleft = TIMEOUT; end
    end else if (m_ph == M_WAITING) begin
      m_need  = ls ? m_need - 1 : STABLE;
      m_tleft = m_tleft - 1;
      if (m_need == 0) begin
        m_ph = M_POWERUP; m_left = INIT;
      end else if (m_tleft == 0) begin
        m_retry++;
        if (m_retry == MAXR) m_ph = M_DEAD;
        else begin m_ph = M_RESETTING; m_left = PLL_RST; end
      end
    end else if (m_ph == M_POWERUP) begin
      if (!ls) begin
        m_ph = M_RESETTING; m_left = PLL_RST; m_lost = 1'b1;
      end else begin
        m_left--;
        if (m_left == 0) begin m_ph = M_RUNNING; m_retry = 0; end
      end
    end else if (m_ph == M_RUNNING) begin
      if (!ls) begin m_ph = M_RESETTING; m_left = PLL_RST; m_lost = 1'b1; end
    end
    void'(m_lock_hist.pop_front());
    m_lock_hist.push_back(l);
  endtask

  task automatic check_model();
    chk("m_pll_reset", 8'(bus.pll_reset), 8'(m_ph == M_RESETTING));
    chk("m_sys_rst",   8'(bus.sys_rst),   8'(m_ph != M_RUNNING));
    chk("m_ready",     8'(bus.ready),     8'(m_ph == M_RUNNING));
    chk("m_fault",     8'(bus.fault),     8'(m_ph == M_DEAD));
    chk("m_lock_lost", 8'(bus.lock_lost), 8'(m_lost));
    chk("m_retry_cnt", 8'(bus.retry_cnt), 8'(m_retry));
  endtask

  // One clock: drive at the falling edge, let the DUT clock, check at the next falling edge.
  task automatic tick(input bit r, input bit l);
    rst = r;
    bus.pll_lock = l;
    @(posedge clkin);
    model_step(r, l);
    @(negedge clkin);
    check_model();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pll_reset"}, 8'(bus.pll_reset), 8'd1);
    chk({tag, "_sys_rst"},   8'(bus.sys_rst),   8'd1);
    chk({tag, "_ready"},     8'(bus.ready),     8'd0);
    chk({tag, "_lock_lost"}, 8'(bus.lock_lost), 8'd0);
    chk({tag, "_retry_cnt"}, 8'(bus.retry_cnt), 8'd0);
    chk({tag, "_fault"},     8'(bus.fault),     8'd0);
  endtask

  // Nominal power-up from a fresh reset: ready exactly 28 cycles later.
  task automatic nominal(input string tag);
    for (int i = 1; i <= 28; i++) begin
      tick(1'b0, 1'b1);
      if (i == 3)  chk({tag, "_prst_hi_c3"}, 8'(bus.pll_reset), 8'd1);
      if (i == 4)  chk({tag, "_prst_lo_c4"}, 8'(bus.pll_reset), 8'd0);
      if (i == 27) chk({tag, "_ready_c27"},  8'(bus.ready),     8'd0);
      if (i == 28) begin
        chk({tag, "_ready_c28"},  8'(bus.ready),     8'd1);
        chk({tag, "_sysrst_c28"}, 8'(bus.sys_rst),   8'd0);
        chk({tag, "_retry_c28"},  8'(bus.retry_cnt), 8'd0);
      end
    end
  endtask

  initial begin
    int lost_at;
    int lost_n;
    bit lvl;
    int run_left;

    bus.pll_lock = 1'b1;
    @(negedge clkin);

    // 1: nominal
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);
    chk_reset_vals("s1_reset");
    nominal("s1");

    // 4: lock drop in RUN, one cycle low
    tick(1'b0, 1'b0);
    lost_at = 0; lost_n = 0;
    for (int j = 1; j <= 32; j++) begin
      tick(1'b0, 1'b1);
      if (bus.lock_lost) begin lost_n++; if (lost_at == 0) lost_at = j; end
      if (j == 2) chk("s4_sysrst_at_lost", 8'(bus.sys_rst), 8'd1);
      if (j == 5) chk("s4_prst_hi_j5",     8'(bus.pll_reset), 8'd1);
      if (j == 6) chk("s4_prst_lo_j6",     8'(bus.pll_reset), 8'd0);
      if (j == 29) chk("s4_ready_j29",     8'(bus.ready), 8'd0);
      if (j == 30) chk("s4_ready_j30",     8'(bus.ready), 8'd1);
    end
    chk("s4_lost_at", 8'(lost_at), 8'd2);
    chk("s4_lost_n",  8'(lost_n),  8'd1);

    // 2: one-cycle glitch at WAITLOCK cycle 5
    tick(1'b1, 1'b1);
    for (int i = 0; i <= 33; i++) begin
      tick(1'b0, (i == 7) ? 1'b0 : 1'b1);
      if (i == 32) chk("s2_ready_c33", 8'(bus.ready), 8'd0);
      if (i == 33) chk("s2_ready_c34", 8'(bus.ready), 8'd1);
    end

    // 3: no lock ever -> two timeouts -> FAULT
    tick(1'b1, 1'b0);
    for (int i = 0; i <= 49; i++) begin
      tick(1'b0, 1'b0);
      if (i == 22) chk("s3_retry_c23", 8'(bus.retry_cnt), 8'd0);
      if (i == 23) begin
        chk("s3_retry_c24", 8'(bus.retry_cnt), 8'd1);
        chk("s3_prst_c24",  8'(bus.pll_reset), 8'd1);
      end
      if (i == 47 || i == 49) begin
        chk("s3_fault",      8'(bus.fault),     8'd1);
        chk("s3_retry_flt",  8'(bus.retry_cnt), 8'd2);
        chk("s3_prst_flt",   8'(bus.pll_reset), 8'd0);
      end
    end

    // 5b: reset out of FAULT
    tick(1'b1, 1'b1);
    chk_reset_vals("s5_fault_rst");
    nominal("s5b");

    // 5a: reset mid-INITWAIT
    tick(1'b1, 1'b1);
    for (int i = 0; i < 20; i++) tick(1'b0, 1'b1);
    tick(1'b1, 1'b1);
    chk_reset_vals("s5_init_rst");
    nominal("s5a");

    // 6: stable completes on the same cycle as the timeout
    tick(1'b1, 1'b0);
    for (int i = 0; i <= 39; i++) begin
      tick(1'b0, (i >= 14) ? 1'b1 : 1'b0);
      if (i == 23) begin
        chk("s6_prst_c24",  8'(bus.pll_reset), 8'd0);
        chk("s6_retry_c24", 8'(bus.retry_cnt), 8'd0);
      end
      if (i == 38) chk("s6_ready_c39", 8'(bus.ready), 8'd0);
      if (i == 39) chk("s6_ready_c40", 8'(bus.ready), 8'd1);
    end

    // Random LOCK runs with occasional reset pulses
    lvl = 1'b1; run_left = 0;
    for (int n = 0; n < 4000; n++) begin
      if (run_left == 0) begin
        lvl = ($urandom_range(0, 3) != 0);
        run_left = lvl ? $urandom_range(1, 80) : $urandom_range(1, 30);
      end
      tick(($urandom_range(0, 299) == 0), lvl);
      run_left--;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
